// File: rtl/music_player.sv
// Note-queue tone generator: each queued word plays a square wave of a given
// half-period (cpu_clk cycles) for a duration in milliseconds.
module music_player #(
  parameter int CLK_HZ     = 16_000_000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        cpu_clk,
  input  logic        rstn,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  output logic        audio_out,
  output logic        busy,
  output logic [7:0]  rd_status
);

  localparam int MS_CYC = CLK_HZ / 1000;
  localparam int PW     = $clog2(MS_CYC);
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam logic [PW-1:0] PRESC_LAST = PW'(MS_CYC - 1);
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
  localparam logic [AW:0]   PTR_ONE    = (AW+1)'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_nx_s;
  logic [31:0]   mem_r [FIFO_DEPTH];
  logic [31:0]   head_s;
  logic [AW:0]   wr_ptr_r;
  logic [AW:0]   rd_ptr_r;
  logic          fifo_empty_s;
  logic          fifo_full_s;
  logic          push_s;
  logic          pop_s;
  logic          overflow_r;
  logic [15:0]   dur_r;
  logic [15:0]   half_r;
  logic [15:0]   remain_r;
  logic [15:0]   tone_cnt_r;
  logic [PW-1:0] presc_r;
  logic          last_tick_s;
  logic          playing_s;

  // The extra pointer bit separates a full queue from an empty one.
  assign fifo_empty_s = (wr_ptr_r == rd_ptr_r);
  assign fifo_full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                        (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign head_s       = mem_r[rd_ptr_r[AW-1:0]];
  assign push_s       = rstn && wr_en && !fifo_full_s;
  assign pop_s        = rstn && (state_r == IDLE) && !fifo_empty_s;
  assign last_tick_s  = (presc_r == PRESC_LAST) && (remain_r == 16'd1);

  // Note storage; contents are don't-care while the pointers say empty.
  always_ff @(posedge cpu_clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
    end
  end

  // Queue pointers and the sticky overflow flag.
  always_ff @(posedge cpu_clk) begin
    if (!rstn) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      overflow_r <= 1'b0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
      if (wr_en && fifo_full_s) overflow_r <= 1'b1;
    end
  end

  // Player state register.
  always_ff @(posedge cpu_clk) begin
    if (!rstn) state_r <= IDLE;
    else       state_r <= state_nx_s;
  end

  // Player next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE:    state_nx_s = fifo_empty_s ? IDLE : LOAD;
      LOAD:    state_nx_s = (dur_r == 16'd0) ? IDLE : PLAY;
      PLAY:    state_nx_s = last_tick_s ? IDLE : PLAY;
      default: state_nx_s = IDLE;
    endcase
  end

  // Note latch, ms prescaler, duration and tone counters, registered audio.
  always_ff @(posedge cpu_clk) begin
    if (!rstn) begin
      dur_r      <= 16'd0;
      half_r     <= 16'd0;
      remain_r   <= 16'd0;
      tone_cnt_r <= 16'd0;
      presc_r    <= '0;
      audio_out  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          audio_out <= 1'b0;
          if (pop_s) begin
            dur_r  <= head_s[31:16];
            half_r <= head_s[15:0];
          end
        end
        LOAD: begin
          audio_out  <= 1'b0;
          presc_r    <= '0;
          remain_r   <= dur_r;
          tone_cnt_r <= (half_r == 16'd0) ? 16'd0 : half_r - 16'd1;
        end
        PLAY: begin
          if (presc_r == PRESC_LAST) begin
            presc_r  <= '0;
            remain_r <= remain_r - 16'd1;
          end else begin
            presc_r <= presc_r + PRESC_ONE;
          end
          // A zero half-period is a rest: the output stays low.
          if (last_tick_s || (half_r == 16'd0)) begin
            audio_out <= 1'b0;
          end else if (tone_cnt_r == 16'd0) begin
            audio_out  <= ~audio_out;
            tone_cnt_r <= half_r - 16'd1;
          end else begin
            tone_cnt_r <= tone_cnt_r - 16'd1;
          end
        end
        default: audio_out <= 1'b0;
      endcase
    end
  end

  // Status outputs decoded from registered state.
  always_comb begin
    playing_s = (state_r == PLAY);
    busy      = (state_r != IDLE) || !fifo_empty_s;
    rd_status = {4'b0000, playing_s, overflow_r, fifo_full_s, busy};
  end

endmodule

// File: tb/tb_music_player.sv
// Self-checking bench for music_player: vector table, directed corner-case
// sequences and random traffic against a queue-based reference model.
module tb_music_player;

  localparam int CLK_HZ = 16_000;
  localparam int FD     = 4;
  localparam int MS     = CLK_HZ / 1000;

  logic        cpu_clk;
  logic        rstn;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        audio_out;
  logic        busy;
  logic [7:0]  rd_status;

  music_player #(.CLK_HZ(CLK_HZ), .FIFO_DEPTH(FD)) dut (
    .cpu_clk  (cpu_clk),
    .rstn     (rstn),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .audio_out(audio_out),
    .busy     (busy),
    .rd_status(rd_status)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Reference model: a note queue plus the currently sounding note, with
  // the waveform derived arithmetically from the cycle index within PLAY.
  logic [31:0] mq[$];
  int          m_mode = 0;  // 0 idle, 1 load, 2 play
  int          m_k    = 0;
  logic [15:0] m_dur  = 16'd0;
  logic [15:0] m_hp   = 16'd0;
  bit          m_ovf  = 1'b0;

  // Observation counters used by the directed sequences.
  int play_cyc    = 0;
  int high_cyc    = 0;
  int play_starts = 0;
  bit prev_play   = 1'b0;
  int starts_q[$];
  int ends_q[$];

  function automatic void model_step(bit r, bit w, logic [31:0] d);
    bit          full_before;
    logic [31:0] cur;
    if (!r) begin
      mq.delete();
      m_mode = 0;
      m_k    = 0;
      m_ovf  = 1'b0;
      return;
    end
    full_before = (mq.size() == FD);
    case (m_mode)
      0: if (mq.size() > 0) begin
        cur    = mq.pop_front();
        m_dur  = cur[31:16];
        m_hp   = cur[15:0];
        m_mode = 1;
      end
      1: begin
        m_mode = (m_dur == 16'd0) ? 0 : 2;
        m_k    = 0;
      end
      default: begin
        m_k++;
        if (m_k == int'(m_dur) * MS) m_mode = 0;
      end
    endcase
    if (w) begin
      if (full_before) m_ovf = 1'b1;
      else mq.push_back(d);
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input bit r, input bit w, input logic [31:0] d);
    logic       e_audio;
    logic       e_busy;
    logic [7:0] e_status;
    rstn    = r;
    wr_en   = w;
    wr_data = d;
    @(posedge cpu_clk);
    model_step(r, w, d);
    #1;
    cyc++;
    e_busy   = (m_mode != 0) || (mq.size() > 0);
    e_audio  = (m_mode == 2 && m_hp != 16'd0) ? (((m_k / int'(m_hp)) % 2) == 1) : 1'b0;
    e_status = {4'b0000, (m_mode == 2), m_ovf, (mq.size() == FD), e_busy};
    chk("model_audio", audio_out, e_audio);
    chk("model_busy", busy, e_busy);
    chk("model_status", rd_status, e_status);
    if (rd_status[3]) play_cyc++;
    if (audio_out) high_cyc++;
    if (rd_status[3] && !prev_play) begin
      play_starts++;
      starts_q.push_back(cyc);
    end
    if (!rd_status[3] && prev_play) ends_q.push_back(cyc);
    prev_play = rd_status[3];
  endtask

  task automatic clear_counters();
    play_cyc    = 0;
    high_cyc    = 0;
    play_starts = 0;
    starts_q.delete();
    ends_q.delete();
  endtask

  task automatic run_until_idle(input int bound);
    for (int i = 0; i < bound && busy; i++) tick(1'b1, 1'b0, 32'h0000_0000);
    chk("idle_timeout", busy, 32'd0);
  endtask

  typedef struct {
    logic        rstn;
    logic        wr;
    logic [31:0] data;
    logic [7:0]  exp_status;
    logic        exp_audio;
  } vec_t;

  vec_t vt[10];

  initial begin
    rstn    = 1'b0;
    wr_en   = 1'b0;
    wr_data = 32'h0000_0000;

    // Reset (write ignored) followed by the opening cycles of one note.
    vt[0] = '{1'b0, 1'b1, 32'hDEAD_BEEF, 8'h00, 1'b0};
    vt[1] = '{1'b0, 1'b0, 32'h0000_0000, 8'h00, 1'b0};
    vt[2] = '{1'b1, 1'b1, 32'h0002_0004, 8'h01, 1'b0};
    vt[3] = '{1'b1, 1'b0, 32'h0000_0000, 8'h01, 1'b0};
    vt[4] = '{1'b1, 1'b0, 32'h0000_0000, 8'h09, 1'b0};
    vt[5] = '{1'b1, 1'b0, 32'h0000_0000, 8'h09, 1'b0};
    vt[6] = '{1'b1, 1'b0, 32'h0000_0000, 8'h09, 1'b0};
    vt[7] = '{1'b1, 1'b0, 32'h0000_0000, 8'h09, 1'b0};
    vt[8] = '{1'b1, 1'b0, 32'h0000_0000, 8'h09, 1'b1};
    vt[9] = '{1'b1, 1'b0, 32'h0000_0000, 8'h09, 1'b1};

    // Single note 0x0002_0004.
    for (int i = 0; i < 10; i++) begin
      tick(vt[i].rstn, vt[i].wr, vt[i].data);
      chk($sformatf("vec%0d_status", i), rd_status, vt[i].exp_status);
      chk($sformatf("vec%0d_audio", i), audio_out, vt[i].exp_audio);
    end
    run_until_idle(100);
    chk("single_play_len", play_cyc, 32'd32);
    chk("single_high_cyc", high_cyc, 32'd16);
    chk("single_end_status", rd_status, 32'h00);
    chk("single_end_audio", audio_out, 32'd0);

    // Rest then zero-duration skip.
    clear_counters();
    tick(1'b1, 1'b1, 32'h0001_0000);
    tick(1'b1, 1'b1, 32'h0000_0005);
    run_until_idle(100);
    chk("rest_play_len", play_cyc, 32'd16);
    chk("rest_high_cyc", high_cyc, 32'd0);
    chk("rest_play_starts", play_starts, 32'd1);

    // Overflow: five writes while note 1 plays.
    tick(1'b0, 1'b0, 32'h0000_0000);
    clear_counters();
    tick(1'b1, 1'b1, 32'h0001_0002);
    tick(1'b1, 1'b0, 32'h0000_0000);
    tick(1'b1, 1'b0, 32'h0000_0000);
    chk("ovf_playing", rd_status, 32'h09);
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b1, {16'd1, 16'(3 + i)});
      if (i == 3) chk("ovf_full", rd_status, 32'h0B);
      if (i == 4) chk("ovf_set", rd_status, 32'h0F);
    end
    run_until_idle(500);
    chk("ovf_sticky", rd_status, 32'h04);
    chk("ovf_play_starts", play_starts, 32'd5);
    chk("ovf_play_len", play_cyc, 32'd80);

    // Write dropped while full even though the player pops that cycle.
    tick(1'b0, 1'b0, 32'h0000_0000);
    clear_counters();
    tick(1'b1, 1'b1, 32'h0001_0002);
    tick(1'b1, 1'b0, 32'h0000_0000);
    tick(1'b1, 1'b0, 32'h0000_0000);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 32'h0001_0003);
    chk("pop_full_filled", rd_status, 32'h0B);
    for (int i = 0; i < 64 && rd_status[3]; i++) tick(1'b1, 1'b0, 32'h0000_0000);
    chk("pop_full_idle", rd_status, 32'h03);
    tick(1'b1, 1'b1, 32'h0001_0005);
    chk("pop_full_drop", rd_status, 32'h05);
    run_until_idle(500);
    chk("pop_full_starts", play_starts, 32'd5);

    // Reset mid-note with two notes queued.
    tick(1'b0, 1'b0, 32'h0000_0000);
    tick(1'b1, 1'b1, 32'h0002_0003);
    tick(1'b1, 1'b1, 32'h0001_0004);
    tick(1'b1, 1'b1, 32'h0001_0005);
    tick(1'b1, 1'b0, 32'h0000_0000);
    tick(1'b1, 1'b0, 32'h0000_0000);
    chk("rst_mid_playing", rd_status, 32'h09);
    tick(1'b0, 1'b1, 32'h0001_0006);
    chk("rst_mid_status", rd_status, 32'h00);
    chk("rst_mid_audio", audio_out, 32'd0);
    clear_counters();
    for (int i = 0; i < 100; i++) tick(1'b1, 1'b0, 32'h0000_0000);
    chk("rst_mid_no_play", play_cyc, 32'd0);
    chk("rst_mid_busy", busy, 32'd0);

    // Back-to-back notes.
    clear_counters();
    tick(1'b1, 1'b1, 32'h0001_0002);
    tick(1'b1, 1'b1, 32'h0001_0003);
    run_until_idle(200);
    chk("b2b_starts", play_starts, 32'd2);
    if (starts_q.size() == 2 && ends_q.size() >= 1) begin
      chk("b2b_gap", starts_q[1] - ends_q[0], 32'd2);
    end else begin
      chk("b2b_edges", starts_q.size(), 32'd2);
    end
    chk("b2b_high_cyc", high_cyc, 32'd15);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      tick(($urandom_range(0, 399) != 0), ($urandom_range(0, 5) == 0),
           {16'($urandom_range(0, 2)), 16'($urandom_range(0, 6))});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
